// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// fifo_wr_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares the single write port of a FIFO between NUM_REQ valid/ready
//   requesters. Arbitration is round-robin at beat level. A multi-beat packet
//   locks the grant from its first accepted beat through the beat flagged by
//   req_last. The arbiter sits directly in front of the FIFO write interface
//   (data_in / data_in_valid / data_in_ready) in the same clock domain.
//
//   The grant, data and ready paths are purely combinational, so a beat is
//   accepted in the same cycle it is presented. Arbitration state (round-robin
//   pointer, lock owner, IDLE/BURST) only moves on the clock edge after a
//   handshake.
//
// Parameters:
//   NUM_REQ    - number of requesters (>= 2)
//   DATA_WIDTH - payload width, identical to the FIFO word
//   ID_W       - width of grant_id, $clog2(NUM_REQ)
//
// Ports:
//   clk_i          in   1                   clock, all logic on posedge
//   rst_n          in   1                   synchronous active-low reset
//   req_data       in   NUM_REQ*DATA_WIDTH  payloads, requester k at
//                                           [k*DATA_WIDTH +: DATA_WIDTH]
//   req_valid      in   NUM_REQ             per-requester beat valid
//   req_last       in   NUM_REQ             last beat of a packet
//   req_ready      out  NUM_REQ             per-requester accept, one-hot/zero
//   data_in        out  DATA_WIDTH          payload to the FIFO
//   data_in_valid  out  1                   beat valid to the FIFO
//   data_in_ready  in   1                   FIFO can take a beat
//   grant_id       out  ID_W                currently granted requester
//   locked         out  1                   a packet is in progress
// ============================================================================
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          data_in_valid,
    input  logic                          data_in_ready,
    output logic [ID_W-1:0]               grant_id,
    output logic                          locked
);

    // ------------------------------------------------------------------------
    // Types and helpers
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Modulo-NUM_REQ addition. The wrap is explicit so that a NUM_REQ that is
    // not a power of two never produces an index past the last requester.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int              offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return ID_W'(sum);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e          state_q,   state_d;
    logic [ID_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;

    // Combinational datapath
    logic [ID_W-1:0]       idle_sel_s;
    logic                  idle_hit_s;
    logic [ID_W-1:0]       grant_s;
    logic [DATA_WIDTH-1:0] data_sel_s;
    logic                  valid_sel_s;
    logic                  last_sel_s;
    logic                  fire_s;
    logic [NUM_REQ-1:0]    ready_vec_s;

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        idle_sel_s = rr_ptr_q;
        idle_hit_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!idle_hit_s && req_valid[wrap_add(rr_ptr_q, i)]) begin
                idle_sel_s = wrap_add(rr_ptr_q, i);
                idle_hit_s = 1'b1;
            end else begin
                idle_hit_s = idle_hit_s;
            end
        end
    end

    // Grant selection: lock owner in BURST, scan winner in IDLE, requester 0
    // while reset is held so the FIFO sees a quiet, deterministic port.
    always_comb begin
        grant_s = {ID_W{1'b0}};
        if (!rst_n) begin
            grant_s = {ID_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE:  grant_s = idle_sel_s;
                ST_BURST: grant_s = lock_id_q;
                default:  grant_s = {ID_W{1'b0}};
            endcase
        end
    end

    // Payload/valid/last mux for the granted requester, plus the handshake.
    always_comb begin
        data_sel_s  = req_data[int'(grant_s)*DATA_WIDTH +: DATA_WIDTH];
        valid_sel_s = req_valid[grant_s] & rst_n;
        last_sel_s  = req_last[grant_s];
        fire_s      = valid_sel_s & data_in_ready;
    end

    // Ready fan-out: only the granted requester sees the FIFO's ready. It is
    // deliberately not qualified by that requester's own valid.
    always_comb begin
        ready_vec_s = {NUM_REQ{1'b0}};
        if (rst_n) begin
            ready_vec_s[grant_s] = data_in_ready;
        end else begin
            ready_vec_s = {NUM_REQ{1'b0}};
        end
    end

    // Next-state logic: arbitration state only moves on a handshake.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        if (fire_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (last_sel_s) begin
                        // Single-beat packet: pass priority to the next one.
                        rr_ptr_d = wrap_add(grant_s, 1);
                    end else begin
                        state_d   = ST_BURST;
                        lock_id_d = grant_s;
                    end
                end
                ST_BURST: begin
                    if (last_sel_s) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = wrap_add(lock_id_q, 1);
                    end else begin
                        state_d = ST_BURST;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State register with synchronous active-low reset; a partial packet is
    // simply abandoned on reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= {ID_W{1'b0}};
            lock_id_q <= {ID_W{1'b0}};
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (combinational: zero-latency acceptance)
    // ------------------------------------------------------------------------
    assign req_ready     = ready_vec_s;
    assign data_in       = data_sel_s;
    assign data_in_valid = valid_sel_s;
    assign grant_id      = grant_s;
    assign locked        = rst_n & (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: requester queues feed the DUT, expected beats are
// queued in arbitration order and popped whenever the FIFO side handshakes.
module tb_fifo_wr_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int IDW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (NUM_REQ = 4)
    logic               rst_n;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_last;
    logic [NR-1:0]      req_ready;
    logic [DW-1:0]      data_in;
    logic               data_in_valid;
    logic               data_in_ready;
    logic [IDW-1:0]     grant_id;
    logic               locked;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_n(rst_n), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .data_in(data_in),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .grant_id(grant_id), .locked(locked)
    );

    // Second DUT (NUM_REQ = 3) for the non-power-of-two wrap
    logic               rst3_n;
    logic [3*DW-1:0]    req_data3;
    logic [2:0]         req_valid3;
    logic [2:0]         req_last3;
    logic [2:0]         req_ready3;
    logic [DW-1:0]      data_in3;
    logic               data_in_valid3;
    logic               data_in_ready3;
    logic [1:0]         grant_id3;
    logic               locked3;

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW)) dut3 (
        .clk_i(clk), .rst_n(rst3_n), .req_data(req_data3), .req_valid(req_valid3),
        .req_last(req_last3), .req_ready(req_ready3), .data_in(data_in3),
        .data_in_valid(data_in_valid3), .data_in_ready(data_in_ready3),
        .grant_id(grant_id3), .locked(locked3)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } exp_t;

    exp_t         expq[$];
    logic [DW-1:0] srcd[NR][$];
    logic          srcl[NR][$];
    logic [NR-1:0] en;
    logic [NR-1:0] accepted;
    int errors = 0;
    int checks = 0;

    // Queue a packet of nbeats on requester k; single=1 makes every beat last.
    task automatic load(input int k, input int nbeats, input logic [DW-1:0] base,
                        input bit single);
        for (int b = 0; b < nbeats; b++) begin
            srcd[k].push_back(base + DW'(b));
            srcl[k].push_back(single || (b == nbeats - 1));
        end
    endtask

    task automatic push_exp(input int id, input logic [DW-1:0] d);
        exp_t e;
        e.id   = IDW'(id);
        e.data = d;
        expq.push_back(e);
    endtask

    // Present the head beat of every enabled requester, then wait for negedge.
    task automatic pre();
        for (int k = 0; k < NR; k++) begin
            if (en[k] && srcd[k].size() > 0) begin
                req_valid[k]             = 1'b1;
                req_data[k*DW +: DW]     = srcd[k][0];
                req_last[k]              = srcl[k][0];
            end else begin
                req_valid[k] = 1'b0;
                req_last[k]  = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Scoreboard on the FIFO side, then advance one clock and retire beats.
    task automatic tick();
        exp_t e;
        if (data_in_valid && data_in_ready) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got id=%0d data=%h, required no beat", grant_id, data_in);
            end else begin
                e = expq.pop_front();
                if (grant_id !== e.id || data_in !== e.data) begin
                    errors++;
                    $display("FAIL beat_order: got id=%0d data=%h, required id=%0d data=%h",
                             grant_id, data_in, e.id, e.data);
                end
            end
            checks++;
            if (req_ready !== (4'b0001 << grant_id)) begin
                errors++;
                $display("FAIL ready_onehot: got %b for grant %0d", req_ready, grant_id);
            end
        end
        accepted = req_ready & req_valid;
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (accepted[k]) begin
                void'(srcd[k].pop_front());
                void'(srcl[k].pop_front());
            end
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats still expected, required 0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        data_in_ready = 1'b1;
        req_valid     = 4'b1111;
        req_last      = 4'b1111;
        req_data      = 32'h44332211;
        en            = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000 || data_in_valid !== 1'b0 || locked !== 1'b0 ||
                grant_id !== 2'd0 || data_in !== 8'h11) begin
                errors++;
                $display("FAIL reset_outputs: ready=%b valid=%b locked=%b grant=%0d data=%h, required 0000 0 0 0 11",
                         req_ready, data_in_valid, locked, grant_id, data_in);
            end
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        @(negedge clk);
        checks++;
        if (grant_id !== 2'd0 || locked !== 1'b0 || data_in_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: grant=%0d locked=%b valid=%b, required 0 0 0",
                     grant_id, locked, data_in_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < NR; k++) load(k, 2, DW'(k * 16), 1'b1);
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < NR; k++) push_exp(k, DW'(k * 16 + b));
        en = 4'b1111;
        for (int c = 0; c < 20 && expq.size() > 0; c++) begin
            pre();
            checks++;
            if (locked !== 1'b0 || data_in_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_stream: locked=%b valid=%b, required 0 1", locked, data_in_valid);
            end
            tick();
        end
        check_drained("rr");
    endtask

    task automatic test_burst();
        int lock_cycles;
        lock_cycles = 0;
        load(2, 3, 8'h20, 1'b0);
        load(0, 1, 8'h05, 1'b1);
        push_exp(2, 8'h20);
        push_exp(2, 8'h21);
        push_exp(2, 8'h22);
        push_exp(0, 8'h05);
        for (int c = 0; c < 12 && expq.size() > 0; c++) begin
            en = (c >= 1) ? 4'b0101 : 4'b0100;
            pre();
            if (locked === 1'b1) lock_cycles++;
            tick();
        end
        check_drained("burst");
        checks++;
        if (lock_cycles != 2) begin
            errors++;
            $display("FAIL burst_lock_cycles: got %0d, required 2", lock_cycles);
        end
    endtask

    task automatic test_backpressure();
        load(1, 4, 8'h10, 1'b0);
        load(0, 1, 8'h07, 1'b1);
        load(2, 1, 8'h27, 1'b1);
        load(3, 1, 8'h37, 1'b1);
        push_exp(1, 8'h10);
        push_exp(1, 8'h11);
        push_exp(1, 8'h12);
        push_exp(1, 8'h13);
        push_exp(2, 8'h27);
        push_exp(3, 8'h37);
        push_exp(0, 8'h07);
        en = 4'b1111;
        for (int c = 0; c < 20 && expq.size() > 0; c++) begin
            data_in_ready = !(c >= 1 && c <= 5);
            pre();
            if (c >= 1 && c <= 5) begin
                checks++;
                if (req_ready !== 4'b0000 || grant_id !== 2'd1 || locked !== 1'b1 ||
                    data_in_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL full_hold: ready=%b grant=%0d locked=%b valid=%b, required 0000 1 1 1",
                             req_ready, grant_id, locked, data_in_valid);
                end
            end
            tick();
        end
        data_in_ready = 1'b1;
        check_drained("bp");
    endtask

    task automatic test_idle();
        en = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            pre();
            checks++;
            if (data_in_valid !== 1'b0 || grant_id !== 2'd1 || locked !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold: valid=%b grant=%0d locked=%b, required 0 1 0",
                         data_in_valid, grant_id, locked);
            end
            tick();
        end
        // Lone two-beat packet from requester 2 leaves the pointer at 3.
        load(2, 2, 8'h28, 1'b0);
        push_exp(2, 8'h28);
        push_exp(2, 8'h29);
        for (int c = 0; c < 8 && expq.size() > 0; c++) begin
            pre();
            tick();
        end
        check_drained("idle_pkt");
        pre();
        checks++;
        if (grant_id !== 2'd3 || data_in_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_after_packet: grant=%0d valid=%b, required 3 0", grant_id, data_in_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        load(3, 4, 8'h30, 1'b0);
        load(0, 1, 8'h01, 1'b1);
        load(1, 1, 8'h11, 1'b1);
        load(2, 1, 8'h21, 1'b1);
        en = 4'b1111;
        push_exp(3, 8'h30);
        pre();
        tick();
        pre();
        checks++;
        if (locked !== 1'b1 || grant_id !== 2'd3) begin
            errors++;
            $display("FAIL lock_on_3: locked=%b grant=%0d, required 1 3", locked, grant_id);
        end
        rst_n = 1'b0;
        repeat (2) begin
            pre();
            checks++;
            if (data_in_valid !== 1'b0 || req_ready !== 4'b0000 || locked !== 1'b0 ||
                grant_id !== 2'd0 || data_in !== 8'h01) begin
                errors++;
                $display("FAIL reset_mid_burst: valid=%b ready=%b locked=%b grant=%0d data=%h, required 0 0000 0 0 01",
                         data_in_valid, req_ready, locked, grant_id, data_in);
            end
            tick();
        end
        rst_n = 1'b1;
        push_exp(0, 8'h01);
        push_exp(1, 8'h11);
        push_exp(2, 8'h21);
        push_exp(3, 8'h31);
        push_exp(3, 8'h32);
        push_exp(3, 8'h33);
        for (int c = 0; c < 16 && expq.size() > 0; c++) begin
            pre();
            if (c == 0) begin
                checks++;
                if (locked !== 1'b0 || grant_id !== 2'd0) begin
                    errors++;
                    $display("FAIL post_reset_grant: locked=%b grant=%0d, required 0 0", locked, grant_id);
                end
            end
            tick();
        end
        check_drained("rst_mid");
    endtask

    task automatic test_wrap3();
        int exp3[$];
        int id;
        en             = 4'b0000;
        rst3_n         = 1'b0;
        data_in_ready3 = 1'b1;
        req_valid3     = 3'b111;
        req_last3      = 3'b111;
        req_data3      = 24'hA2A1A0;
        @(posedge clk);
        #1;
        rst3_n = 1'b1;
        exp3 = '{0, 1, 2, 0, 1};
        for (int c = 0; c < 10 && exp3.size() > 0; c++) begin
            @(negedge clk);
            if (data_in_valid3 && data_in_ready3) begin
                id = exp3.pop_front();
                checks++;
                if (grant_id3 !== 2'(id) || data_in3 !== (8'hA0 + 8'(id)) || locked3 !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap3: got id=%0d data=%h locked=%b, required id=%0d data=%h locked=0",
                             grant_id3, data_in3, locked3, id, 8'hA0 + 8'(id));
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp3.size() != 0) begin
            errors++;
            $display("FAIL wrap3_drain: %0d grants missing, required 0", exp3.size());
        end
    endtask

    initial begin
        rst3_n         = 1'b0;
        req_data3      = 24'h0;
        req_valid3     = 3'b000;
        req_last3      = 3'b000;
        data_in_ready3 = 1'b1;
        accepted       = 4'b0000;
        test_reset();
        test_round_robin();
        test_burst();
        test_backpressure();
        test_idle();
        test_reset_mid_burst();
        test_wrap3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
